// File: rtl/dac_sample_scheduler_if.sv
// Valid/ready sample stream from the upstream PCM source into the DAC scheduler.
// The master drives data and valid; the slave returns ready.
interface dac_sample_scheduler_if #(
  parameter int BW = 16
);
  logic [BW-1:0] data;
  logic          valid;
  logic          ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/dac_sample_scheduler.sv
// Sample-rate controller for the delta-sigma DAC core. It buffers PCM samples in a FIFO
// and releases one sample to dac_o every (period+1) enabled cycles, with mute and underflow handling.
module dac_sample_scheduler #(
  parameter int BW        = 16,
  parameter int DEPTH     = 8,
  parameter int PW        = 12,
  parameter int HOLD_LAST = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [PW-1:0]            period_i,
  input  logic                     mute_i,
  input  logic                     clr_i,
  dac_sample_scheduler_if.slave    s,
  output logic [BW-1:0]            dac_o,
  output logic                     strobe_o,
  output logic                     underflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] level_nxt;
  logic [PW-1:0] cnt;
  logic [PW-1:0] per;
  logic [BW-1:0] dac_nxt;
  logic          full;
  logic          empty;
  logic          push;
  logic          tick;
  logic          pop;

  // Handshake, tick decode, occupancy update and the sample chosen for the next tick
  always_comb begin
    full      = (level == LW'(DEPTH));
    empty     = (level == LW'(0));
    push      = s.valid && !full;
    tick      = en_i && (cnt == per);
    pop       = tick && !empty;
    level_nxt = level;
    dac_nxt   = BW'(0);
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
    // Mute still consumes the head so the stream keeps its timing
    if (mute_i) begin
      dac_nxt = BW'(0);
    end else if (!empty) begin
      dac_nxt = mem[rd_ptr];
    end else if (HOLD_LAST != 0) begin
      dac_nxt = dac_o;
    end else begin
      dac_nxt = BW'(0);
    end
  end

  assign s.ready = !full;
  assign level_o = level;

  // Sample storage; no reset needed since occupancy gates every read
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr] <= s.data;
    end
  end

  // Pointers, period counter, output sample and status flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= AW'(0);
      rd_ptr      <= AW'(0);
      level       <= LW'(0);
      cnt         <= PW'(0);
      per         <= period_i;
      dac_o       <= BW'(0);
      strobe_o    <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_nxt;

      // A new period value is only picked up at the tick that closes the current one
      if (!en_i) begin
        cnt <= PW'(0);
      end else if (tick) begin
        cnt <= PW'(0);
        per <= period_i;
      end else begin
        cnt <= cnt + PW'(1);
      end

      strobe_o <= tick;
      if (tick) begin
        dac_o <= dac_nxt;
      end

      if (tick && empty) begin
        underflow_o <= 1'b1;
      end else if (clr_i) begin
        underflow_o <= 1'b0;
      end
    end
  end

endmodule
